// File: rtl/cast_switch_alloc.sv
// Multicast switch allocator: grants each head flit all of its requested outputs at once,
// holds the connection until the tail and forwards flits only when every branch is ready.
`ifndef PN
`define PN 5
`endif

module cast_switch_alloc #(
  parameter int PN = `PN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i    [PN],
  input  logic          head_i     [PN],
  input  logic          tail_i     [PN],
  input  logic [PN-1:0] req_i      [PN],
  input  logic          ready_i    [PN],
  output logic [PN-1:0] xbar_sel_o [PN],
  output logic          send_o     [PN],
  output logic          fire_o     [PN],
  output logic [PN-1:0] busy_o
);

  localparam int PW = (PN > 1) ? $clog2(PN) : 1;

  logic [PN-1:0] lock_mask [PN];
  logic [PW-1:0] ptr;

  logic [PN-1:0] owned;
  logic [PN-1:0] locked;
  logic [PN-1:0] cand;
  logic [PN-1:0] drop;
  logic [PN-1:0] send;
  logic [PN-1:0] grant;
  logic [PN-1:0] ready_vec;
  logic [PW-1:0] ptr_nxt;

  always_comb begin
    owned     = '0;
    locked    = '0;
    cand      = '0;
    drop      = '0;
    send      = '0;
    ready_vec = '0;
    for (int o = 0; o < PN; o++) begin
      ready_vec[o] = ready_i[o];
    end
    for (int i = 0; i < PN; i++) begin
      owned     = owned | lock_mask[i];
      locked[i] = |lock_mask[i];
      cand[i]   = ~locked[i] & valid_i[i] & head_i[i] & (|req_i[i]);
      drop[i]   = ~locked[i] & valid_i[i] & head_i[i] & ~(|req_i[i]);
      // Synchronous fork: every selected branch must be ready, or none moves.
      send[i]   = locked[i] & valid_i[i] & (&(ready_vec | ~lock_mask[i]));
    end
  end

  // Round-robin allocation starting at ptr; the pointer input reserves its outputs even when blocked.
  always_comb begin
    logic [PN-1:0] avail;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    avail = ~owned;
    grant = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < PN; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(PN)) begin
        sum = sum - (PW+1)'(PN);
      end
      idx = sum[PW-1:0];
      if (cand[idx]) begin
        if ((req_i[idx] & ~avail) == '0) begin
          grant[idx] = 1'b1;
          avail      = avail & ~req_i[idx];
        end else if (k == 0) begin
          avail = avail & ~req_i[idx];
        end
      end
    end
  end

  always_comb begin
    ptr_nxt = ptr;
    if (grant[ptr] | ~cand[ptr]) begin
      ptr_nxt = (ptr == PW'(PN - 1)) ? '0 : ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      for (int i = 0; i < PN; i++) begin
        lock_mask[i] <= '0;
      end
    end else begin
      ptr <= ptr_nxt;
      for (int i = 0; i < PN; i++) begin
        if (send[i] & tail_i[i]) begin
          lock_mask[i] <= '0;
        end else if (grant[i]) begin
          lock_mask[i] <= req_i[i];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < PN; i++) begin
      xbar_sel_o[i] = lock_mask[i];
      send_o[i]     = send[i];
      fire_o[i]     = send[i] | drop[i];
    end
    busy_o = owned;
  end

endmodule
